mod_reduce_seq: RTL and testbench

//  Sequential modular reducer that sits directly downstream of the registered array

---
 rtl/mod_reduce_seq.sv | 111 +++++++++++
 tb/tb_mod_reduce_seq.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mod_reduce_seq.sv
// mod_reduce_seq: sequential modular reducer, product mod modulus.
// Restoring shift-subtract, one product bit per clock, MSB first.
// Valid/ready on both sides; enable low aborts back to IDLE.
module mod_reduce_seq #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2*DATA_WIDTH-1:0] in_product,
  input  logic [DATA_WIDTH-1:0]   in_modulus,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_result,
  output logic                    out_error
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int CW = $clog2(PW);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                state, state_nxt;
  logic [PW-1:0]         prod;
  logic [DATA_WIDTH-1:0] modv;
  // Partial remainder. It is always < modv, so DATA_WIDTH bits hold it;
  // the extra bit lives only in the shifted trial value t.
  logic [DATA_WIDTH-1:0] rem, rem_nxt;
  logic [DATA_WIDTH:0]   t;
  logic [CW-1:0]         cnt;
  logic                  accept;

  assign accept = in_valid && in_ready;

  // One restoring step: shift in the next product bit, subtract if it fits.
  always_comb begin
    t       = {rem, prod[cnt]};
    rem_nxt = t[DATA_WIDTH-1:0];
    if (t >= {1'b0, modv})
      rem_nxt = DATA_WIDTH'(t - {1'b0, modv});
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; enable low wins over everything.
  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (accept) state_nxt = (in_modulus == '0) ? DONE : CALC;
        CALC: if (cnt == '0) state_nxt = DONE;
        DONE: if (out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Handshake outputs decode state only (no path from in_valid/out_ready).
  always_comb begin
    in_ready  = enable && (state == IDLE);
    out_valid = (state == DONE);
  end

  // Datapath: operand capture, shift-subtract iteration, result write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod       <= '0;
      modv       <= '0;
      rem        <= '0;
      cnt        <= '0;
      out_result <= '0;
      out_error  <= 1'b0;
    end else if (!enable) begin
      prod       <= '0;
      modv       <= '0;
      rem        <= '0;
      cnt        <= '0;
      out_result <= '0;
      out_error  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          prod      <= in_product;
          modv      <= in_modulus;
          rem       <= '0;
          cnt       <= CW'(PW - 1);
          out_error <= 1'b0;
          if (in_modulus == '0) begin
            out_error  <= 1'b1;
            out_result <= '0;
          end
        end
        CALC: begin
          rem <= rem_nxt;
          if (cnt == '0) out_result <= rem_nxt;
          else           cnt        <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_reduce_seq.sv
// tb_mod_reduce_seq: directed + random checks of mod_reduce_seq at DATA_WIDTH=8.
module tb_mod_reduce_seq;

  localparam int W = 8;

  logic           clk, rst_n, enable, in_valid, in_ready;
  logic [2*W-1:0] in_product;
  logic [W-1:0]   in_modulus;
  logic           out_valid, out_ready, out_error;
  logic [W-1:0]   out_result;

  int n_chk = 0;
  int n_err = 0;

  mod_reduce_seq #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_product(in_product), .in_modulus(in_modulus),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_error(out_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op from IDLE, wait for DONE, check latency/result/error,
  // optionally release it with a one-cycle out_ready.
  task automatic run_op(input logic [15:0] p, input logic [7:0] m,
                        input logic [7:0] er, input logic ee, input int elat,
                        input bit rel);
    int lat;
    in_product = p;
    in_modulus = m;
    in_valid   = 1'b1;
    step();
    in_valid   = 1'b0;
    in_product = 16'($urandom);
    in_modulus = 8'($urandom);
    lat = 0;
    while (!out_valid && lat < 100) begin
      step();
      lat++;
    end
    chk("lat", lat, elat);
    chk("res", out_result, er);
    chk("err", out_error, ee);
    if (rel) begin
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("idle_rdy", in_ready, 1);
    end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_product = '0; in_modulus = '0;
    #3;
    chk("rst_res", out_result, 0);
    chk("rst_err", out_error, 0);
    chk("rst_vld", out_valid, 0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("rst_rdy", in_ready, 1);

    // Basic reductions
    run_op(16'h1234, 8'h0B, 8'h07, 1'b0, 16, 1'b1);
    run_op(16'hFFFF, 8'hFF, 8'h00, 1'b0, 16, 1'b1);
    run_op(16'h00FE, 8'hFF, 8'hFE, 1'b0, 16, 1'b1);
    run_op(16'hABCD, 8'h01, 8'h00, 1'b0, 16, 1'b1);
    run_op(16'h0005, 8'h80, 8'h05, 1'b0, 16, 1'b1);
    run_op(16'hFFFF, 8'h80, 8'h7F, 1'b0, 16, 1'b1);

    // Zero modulus: DONE straight from the accepting edge, error flagged
    run_op(16'h1234, 8'h00, 8'h00, 1'b1, 0, 1'b1);
    run_op(16'h0010, 8'h03, 8'h01, 1'b0, 16, 1'b1);

    // Backpressure in DONE; a new request must not be taken
    run_op(16'h00FE, 8'hFF, 8'hFE, 1'b0, 16, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_product = 16'h0001; in_modulus = 8'h02;
      step();
      chk("bp_res", out_result, 8'hFE);
      chk("bp_rdy", in_ready, 0);
      chk("bp_vld", out_valid, 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_rel_rdy", in_ready, 1);
    chk("bp_rel_vld", out_valid, 0);
    chk("bp_rel_res", out_result, 8'hFE);

    // Abort via enable at CALC step 5
    in_product = 16'h1234; in_modulus = 8'h0B; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    enable = 1'b0;
    step();
    chk("ab_vld", out_valid, 0);
    chk("ab_res", out_result, 0);
    chk("ab_rdy", in_ready, 0);
    enable = 1'b1;
    #1;
    chk("ab_rdy_back", in_ready, 1);
    run_op(16'h1234, 8'h0B, 8'h07, 1'b0, 16, 1'b1);

    // Async reset mid-CALC, between edges
    in_product = 16'h0FFF; in_modulus = 8'h10; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    chk("ar_res", out_result, 0);
    chk("ar_err", out_error, 0);
    chk("ar_vld", out_valid, 0);
    #2 rst_n = 1'b1;
    step();
    chk("ar_rdy", in_ready, 1);
    run_op(16'hFFFF, 8'h80, 8'h7F, 1'b0, 16, 1'b1);

    // Random regression with random out_ready
    for (int k = 0; k < 1000; k++) begin
      logic [15:0] p;
      logic [7:0]  m, er;
      int          cyc;
      bit          hs;
      p = 16'($urandom);
      m = 8'($urandom);
      if (k % 50 == 0) m = 8'h00;
      er = (m == 0) ? 8'h00 : 8'(p % {8'h00, m});
      in_product = p; in_modulus = m; in_valid = 1'b1;
      out_ready = 1'($urandom);
      step();
      in_valid = 1'b0;
      cyc = 0;
      while (!out_valid && cyc < 100) begin
        out_ready = 1'($urandom);
        step();
        cyc++;
      end
      chk("rnd_vld", out_valid, 1);
      chk("rnd_res", out_result, er);
      chk("rnd_err", out_error, (m == 0));
      cyc = 0;
      hs  = 1'b0;
      while (!hs && cyc < 50) begin
        out_ready = 1'($urandom);
        hs = out_ready;
        step();
        cyc++;
      end
      out_ready = 1'b0;
      chk("rnd_rel", in_ready, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
